// File: rtl/board_link_ctrl_if.sv
// Processor-side send/receive signals of the board link controller.
// proc drives the master modport; the link controller takes the slave side.
interface board_link_ctrl_if;
  logic        snd;
  logic [31:0] interface_data;
  logic        tx_busy;
  logic        tx_overflow;
  logic        interrupt_eth;
  logic [31:0] interrupt_source_data;
  logic        rx_frame_err;

  modport master (
    output snd, interface_data,
    input  tx_busy, tx_overflow, interrupt_eth, interrupt_source_data, rx_frame_err
  );

  modport slave (
    input  snd, interface_data,
    output tx_busy, tx_overflow, interrupt_eth, interrupt_source_data, rx_frame_err
  );
endinterface

// File: rtl/board_link_ctrl.sv
// One-wire UART-style link to the opponent board: 32-bit words, start/stop framed,
// one-entry TX holding register, 2-flop synchronised RX with mid-bit sampling.
module board_link_ctrl #(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic              clk,
  input  logic              rst_n,
  board_link_ctrl_if.slave  proc,
  output logic              link_tx,
  input  logic              link_rx
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] C_FULL = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] C_HALF = CW'(CLKS_PER_BIT / 2 - 1);

  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
  typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_WAIT_IDLE} rx_state_t;

  tx_state_t   r_tx_state, w_tx_next;
  logic [CW-1:0] r_tx_cnt;
  logic [4:0]  r_tx_bit;
  logic [31:0] r_tx_shift;
  logic [31:0] r_hold;
  logic        r_hold_full;
  logic        r_tx_ovf;
  logic        r_link_tx;
  logic        w_tx_tick;
  logic        w_tx_load;
  logic        w_tx_line;

  rx_state_t   r_rx_state, w_rx_next;
  logic [CW-1:0] r_rx_cnt;
  logic [4:0]  r_rx_bit;
  logic [31:0] r_rx_shift;
  logic [31:0] r_rx_data;
  logic        r_rx_s1, r_rx_s2, r_rx_prev;
  logic        r_irq;
  logic        r_ferr;
  logic        w_rx;
  logic        w_rx_tick;

  assign w_rx = r_rx_s2;

  // ---------------- TX ----------------
  assign w_tx_tick = (r_tx_cnt == C_FULL);

  always_comb begin
    w_tx_next = r_tx_state;
    w_tx_load = 1'b0;
    w_tx_line = 1'b1;
    unique case (r_tx_state)
      TX_IDLE: begin
        if (r_hold_full) begin
          w_tx_next = TX_START;
          w_tx_load = 1'b1;
        end
      end
      TX_START: begin
        w_tx_line = 1'b0;
        if (w_tx_tick) w_tx_next = TX_DATA;
      end
      TX_DATA: begin
        w_tx_line = r_tx_shift[0];
        if (w_tx_tick && r_tx_bit == 5'd31) w_tx_next = TX_STOP;
      end
      TX_STOP: begin
        if (w_tx_tick) begin
          if (r_hold_full) begin
            w_tx_next = TX_START;
            w_tx_load = 1'b1;
          end else begin
            w_tx_next = TX_IDLE;
          end
        end
      end
      default: w_tx_next = TX_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_tx_state  <= TX_IDLE;
      r_tx_cnt    <= '0;
      r_tx_bit    <= '0;
      r_tx_shift  <= '0;
      r_hold      <= '0;
      r_hold_full <= 1'b0;
      r_tx_ovf    <= 1'b0;
      r_link_tx   <= 1'b1;
    end else begin
      r_tx_state <= w_tx_next;
      // Line is registered, so link_tx trails the state by one cycle.
      r_link_tx  <= w_tx_line;
      if (r_tx_state == TX_IDLE || w_tx_tick) r_tx_cnt <= '0;
      else                                    r_tx_cnt <= r_tx_cnt + 1'b1;
      if (w_tx_load) begin
        r_tx_shift  <= r_hold;
        r_hold_full <= 1'b0;
      end else if (r_tx_state == TX_DATA && w_tx_tick) begin
        r_tx_shift <= r_tx_shift >> 1;
      end
      if (r_tx_state == TX_DATA && w_tx_tick) r_tx_bit <= r_tx_bit + 1'b1;
      if (proc.snd) begin
        if (r_hold_full) begin
          r_tx_ovf <= 1'b1;
        end else begin
          r_hold      <= proc.interface_data;
          r_hold_full <= 1'b1;
        end
      end
    end
  end

  assign link_tx          = r_link_tx;
  assign proc.tx_busy     = (r_tx_state != TX_IDLE) | r_hold_full;
  assign proc.tx_overflow = r_tx_ovf;

  // ---------------- RX ----------------
  always_comb begin
    w_rx_next = r_rx_state;
    w_rx_tick = (r_rx_cnt == C_FULL);
    unique case (r_rx_state)
      RX_IDLE:      if (r_rx_prev && !w_rx) w_rx_next = RX_START;
      RX_START: begin
        w_rx_tick = (r_rx_cnt == C_HALF);
        if (w_rx_tick) w_rx_next = w_rx ? RX_IDLE : RX_DATA;
      end
      RX_DATA:      if (w_rx_tick && r_rx_bit == 5'd31) w_rx_next = RX_STOP;
      RX_STOP:      if (w_rx_tick) w_rx_next = w_rx ? RX_IDLE : RX_WAIT_IDLE;
      RX_WAIT_IDLE: if (w_rx) w_rx_next = RX_IDLE;
      default:      w_rx_next = RX_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_rx_state <= RX_IDLE;
      r_rx_cnt   <= '0;
      r_rx_bit   <= '0;
      r_rx_shift <= '0;
      r_rx_data  <= '0;
      r_rx_s1    <= 1'b1;
      r_rx_s2    <= 1'b1;
      r_rx_prev  <= 1'b1;
      r_irq      <= 1'b0;
      r_ferr     <= 1'b0;
    end else begin
      r_rx_s1    <= link_rx;
      r_rx_s2    <= r_rx_s1;
      r_rx_prev  <= w_rx;
      r_rx_state <= w_rx_next;
      r_irq      <= 1'b0;
      if (r_rx_state == RX_IDLE || r_rx_state == RX_WAIT_IDLE || w_rx_tick) r_rx_cnt <= '0;
      else                                                                 r_rx_cnt <= r_rx_cnt + 1'b1;
      if (r_rx_state == RX_DATA && w_rx_tick) begin
        r_rx_shift <= {w_rx, r_rx_shift[31:1]};
        r_rx_bit   <= r_rx_bit + 1'b1;
      end
      if (r_rx_state == RX_STOP && w_rx_tick) begin
        if (w_rx) begin
          r_rx_data <= r_rx_shift;
          r_irq     <= 1'b1;
        end else begin
          r_ferr <= 1'b1;
        end
      end
    end
  end

  assign proc.interrupt_eth         = r_irq;
  assign proc.interrupt_source_data = r_rx_data;
  assign proc.rx_frame_err          = r_ferr;

endmodule
